alu_iter: RTL and testbench

- Execute-stage ALU. Consumes the 4-bit ALUControl code from the ALU decoder, plus operands A/B from the register file and immediate mux.
- Produces the result and the branch-compare flags.
- Add/sub/logic/compare complete in one cycle. Shifts run as a 1-bit-per-cycle iterative shifter to save area.
- A valid/ready handshake lets the controller stall on shifts.

---
 rtl/alu_iter_pkg.sv | 26 ++
 rtl/alu_iter_shift_step.sv | 18 +
 rtl/alu_iter.sv | 195 +++++++++++++++++++
 tb/tb_alu_iter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_iter_pkg.sv
// Shared core definitions for the execute-stage ALU: datapath width, FSM states
// and the ALUControl codes produced by the ALU decoder.
package alu_iter_pkg;

    localparam int CORE_XLEN = 32;
    localparam int CORE_SHW  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ALUControl codes; 4'hA..4'hF are undefined and yield a zero result.
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SL   = 4'h7;
    localparam logic [3:0] ALU_SR   = 4'h8;
    localparam logic [3:0] ALU_DCR  = 4'h9;

endpackage

// File: rtl/alu_iter_shift_step.sv
// Combinational one-bit shifter: left with zero fill, or right with zero or
// sign (MSB) fill.
module alu_shift_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_data,
    input  logic            i_left,
    input  logic            i_arith,
    output logic [XLEN-1:0] o_data
);

    logic w_fill;

    assign w_fill = i_arith & i_data[XLEN-1];
    assign o_data = i_left ? {i_data[XLEN-2:0], 1'b0}
                           : {w_fill, i_data[XLEN-1:1]};

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU with valid/ready handshake; shifts iterate one bit per cycle
// unless ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int XLEN = CORE_XLEN,
    parameter int SHW  = CORE_SHW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic            arith,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu
);

    // Handshake: an op is accepted on a rising edge with in_valid && in_ready
    // (ready only in IDLE); a result is consumed on a rising edge with
    // out_valid && out_ready (valid only in DONE). Inputs are sampled only at accept.

    state_e          r_state;
    state_e          w_next_state;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_lt;
    logic            r_ltu;

    logic            w_accept;
    logic            w_lt;
    logic            w_ltu;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu_res;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign lt        = r_lt;
    assign ltu       = r_ltu;

    assign w_accept = in_valid && in_ready;
    assign w_shamt  = b[SHW-1:0];
    assign w_lt     = $signed(a) < $signed(b);
    assign w_ltu    = a < b;

`ifdef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0] w_sra;
    assign w_sra = $signed(a) >>> w_shamt;
`else
    logic            w_is_shift;
    logic [XLEN-1:0] r_work;
    logic [SHW-1:0]  r_cnt;
    logic            r_left;
    logic            r_arith;
    logic [XLEN-1:0] w_step_in;
    logic [XLEN-1:0] w_step_out;
    logic            w_step_left;
    logic            w_step_arith;

    assign w_is_shift = (alu_ctrl == ALU_SL) || (alu_ctrl == ALU_SR);

    // The accept edge already performs the first shift, so a shift of n takes
    // n cycles from accept to out_valid.
    assign w_step_in    = (r_state == IDLE) ? a : r_work;
    assign w_step_left  = (r_state == IDLE) ? (alu_ctrl == ALU_SL) : r_left;
    assign w_step_arith = (r_state == IDLE) ? arith : r_arith;

    alu_shift_step #(
        .XLEN(XLEN)
    ) u_shift_step (
        .i_data (w_step_in),
        .i_left (w_step_left),
        .i_arith(w_step_arith),
        .o_data (w_step_out)
    );
`endif

    always_comb begin
        w_alu_res = '0;
        case (alu_ctrl)
            ALU_ADD:          w_alu_res = a + b;
            ALU_SUB, ALU_DCR: w_alu_res = a - b;
            ALU_AND:          w_alu_res = a & b;
            ALU_OR:           w_alu_res = a | b;
            ALU_XOR:          w_alu_res = a ^ b;
            ALU_SLT:          w_alu_res = {{(XLEN-1){1'b0}}, w_lt};
            ALU_SLTU:         w_alu_res = {{(XLEN-1){1'b0}}, w_ltu};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SL:           w_alu_res = a << w_shamt;
            ALU_SR:           w_alu_res = arith ? w_sra : (a >> w_shamt);
`endif
            default:          w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef ALU_FAST_SHIFT_EN
                    w_next_state = DONE;
`else
                    if (w_is_shift && (w_shamt > SHW'(1))) begin
                        w_next_state = SHIFT;
                    end else begin
                        w_next_state = DONE;
                    end
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_next_state = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_lt     <= 1'b0;
            r_ltu    <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            r_work   <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_arith  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_zero <= (a == b);
                        r_lt   <= w_lt;
                        r_ltu  <= w_ltu;
`ifdef ALU_FAST_SHIFT_EN
                        r_result <= w_alu_res;
`else
                        if (!w_is_shift) begin
                            r_result <= w_alu_res;
                        end else if (w_shamt == '0) begin
                            r_result <= a;
                        end else if (w_shamt == SHW'(1)) begin
                            r_result <= w_step_out;
                        end else begin
                            r_work  <= w_step_out;
                            r_cnt   <= w_shamt - SHW'(1);
                            r_left  <= (alu_ctrl == ALU_SL);
                            r_arith <= arith;
                        end
`endif
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                SHIFT: begin
                    r_work <= w_step_out;
                    r_cnt  <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_step_out;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, multi-cycle corner
// sequences and randomized ops checked against a behavioural model.
module tb_alu_iter;
    import alu_iter_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic        arith;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        ltu;

    int n_checks;
    int n_errors;

    alu_iter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .arith    (arith),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .lt       (lt),
        .ltu      (ltu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic        ar;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic        z;
        logic        l;
        logic        u;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Latency rule for shifts: max(shamt,1) iteratively, always 1 with the barrel shifter.
    function automatic int shift_lat(input int n);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        return (n == 0) ? 1 : n;
`endif
    endfunction

    function automatic void ref_op(input logic [3:0] c, input logic ar,
                                   input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic z,
                                   output logic l, output logic u, output int lat);
        int sh;
        logic signed [31:0] sx;
        sh  = int'(y[4:0]);
        sx  = x;
        lat = 1;
        z   = (x == y);
        l   = (sx < $signed(y));
        u   = (x < y);
        case (c)
            ALU_ADD:  r = x + y;
            ALU_SUB:  r = x - y;
            ALU_DCR:  r = x - y;
            ALU_AND:  r = x & y;
            ALU_OR:   r = x | y;
            ALU_XOR:  r = x ^ y;
            ALU_SLT:  r = l ? 32'd1 : 32'd0;
            ALU_SLTU: r = u ? 32'd1 : 32'd0;
            ALU_SL: begin
                r   = x << sh;
                lat = shift_lat(sh);
            end
            ALU_SR: begin
                if (ar) r = sx >>> sh;
                else    r = x >> sh;
                lat = shift_lat(sh);
            end
            default:  r = 32'd0;
        endcase
    endfunction

    // Drives one op, keeps junk on the inputs while busy, checks outputs,
    // holds DONE for 'hold' cycles, then hands the result off.
    task automatic run_op(input string tag, input logic [3:0] c, input logic ar,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ez, input logic el,
                          input logic eu, input int elat, input int hold);
        int          lat;
        logic        busy_ok;
        logic        stable_ok;
        logic [31:0] held;
        check({tag, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        arith    = ar;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        alu_ctrl = 4'($urandom);
        arith    = 1'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 64) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy in_ready"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " result"}, result, er);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, ez});
        check({tag, " lt"}, {31'd0, lt}, {31'd0, el});
        check({tag, " ltu"}, {31'd0, ltu}, {31'd0, eu});
        held      = result;
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (result !== held || !out_valid || in_ready) stable_ok = 1'b0;
        end
        if (hold > 0) check({tag, " hold stable"}, {31'd0, stable_ok}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " released"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] er;
        logic        ez;
        logic        el;
        logic        eu;
        int          elat;
        logic [3:0]  c;
        logic [31:0] x;
        logic [31:0] y;
        logic        ar;
        logic        never_valid;

        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        alu_ctrl  = ALU_ADD;
        arith     = 1'b0;
        a         = 32'd3;
        b         = 32'd4;
        out_ready = 1'b0;

        vecs[0]  = '{ALU_ADD,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b1, 1'b0, 1, 0};
        vecs[1]  = '{ALU_SUB,  1'b0, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1, 0};
        vecs[2]  = '{ALU_SLTU, 1'b0, 32'h5,        32'hFFFFFFF0, 32'h1,        1'b0, 1'b0, 1'b1, 1, 0};
        vecs[3]  = '{ALU_SR,   1'b1, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, shift_lat(31), 0};
        vecs[4]  = '{ALU_SR,   1'b0, 32'h80000000, 32'd31,       32'h1,        1'b0, 1'b1, 1'b0, shift_lat(31), 0};
        vecs[5]  = '{ALU_SL,   1'b0, 32'h1,        32'h20,       32'h1,        1'b0, 1'b1, 1'b1, 1, 0};
        vecs[6]  = '{ALU_SL,   1'b0, 32'h1,        32'h4,        32'h10,       1'b0, 1'b1, 1'b1, shift_lat(4), 5};
        vecs[7]  = '{ALU_XOR,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1, 1'b1, 1, 0};
        vecs[8]  = '{ALU_OR,   1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b1, 1, 0};
        vecs[9]  = '{ALU_AND,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b1, 1, 5};
        vecs[10] = '{ALU_DCR,  1'b0, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0, 1'b0, 1, 0};
        vecs[11] = '{4'hF,     1'b0, 32'h3,        32'h2,        32'h0,        1'b0, 1'b0, 1'b0, 1, 0};
        vecs[12] = '{ALU_SLT,  1'b0, 32'h80000000, 32'h0,        32'h1,        1'b0, 1'b1, 1'b0, 1, 0};
        vecs[13] = '{ALU_SR,   1'b1, 32'h80000010, 32'd4,        32'hF8000001, 1'b0, 1'b1, 1'b0, shift_lat(4), 2};

        // Reset held for two edges with in_valid high: nothing is accepted.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset in_ready", {31'd0, in_ready}, 32'd1);
            check("reset out_valid", {31'd0, out_valid}, 32'd0);
            check("reset result", result, 32'd0);
            check("reset flags", {29'd0, zero, lt, ltu}, 32'd0);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset out_valid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].ar, vecs[i].x, vecs[i].y,
                   vecs[i].r, vecs[i].z, vecs[i].l, vecs[i].u, vecs[i].lat, vecs[i].hold);
        end

`ifndef ALU_FAST_SHIFT_EN
        // Reset lands mid-shift: the op is dropped and never produces a result.
        in_valid = 1'b1;
        alu_ctrl = ALU_SR;
        arith    = 1'b0;
        a        = 32'hDEADBEEF;
        b        = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
        end
        check("midshift busy", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("midshift reset in_ready", {31'd0, in_ready}, 32'd1);
        check("midshift reset result", result, 32'd0);
        never_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) never_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("midshift no output", {31'd0, never_valid}, 32'd1);
        run_op("after midshift", ALU_ADD, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b1, 1'b1, 1, 0);
`endif

        for (int n = 0; n < 150; n++) begin
            c  = 4'($urandom_range(0, 15));
            ar = 1'($urandom);
            x  = $urandom;
            y  = ($urandom_range(0, 7) == 0) ? x : $urandom;
            ref_op(c, ar, x, y, er, ez, el, eu, elat);
            run_op($sformatf("rnd%0d op%0h", n, c), c, ar, x, y, er, ez, el, eu, elat,
                   $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
